button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Per-button input conditioner for the SLC-3 board top: 2-FF synchronizer, debounce, edge detect.
//  Sits directly upstream of the top level; converts raw active-low KEY inputs (Run, Continue, ...)
//  into clean active-high levels and one-cycle press/release pulses consumed by the slc3 core.
// PARAMETERS
//  WIDTH            2        number of independent button channels
//  DEBOUNCE_CYCLES  500000   consecutive stable synced samples required to accept a new level (>=1)
//  REPEAT_DELAY     25000000 cycles held before first auto-repeat pulse (only with AUTO_REPEAT_EN)
//  REPEAT_PERIOD    5000000  cycles between subsequent auto-repeat pulses (only with AUTO_REPEAT_EN)
// PORTS
//  Clk            in   1      system clock; all logic on posedge
//  Reset          in   1      synchronous, active-high reset
//  btn_n          in   WIDTH  raw asynchronous buttons, active-low (0 = pressed)
//  level_ah       out  WIDTH  debounced button state, active-high (1 = pressed)
//  press_pulse    out  WIDTH  1-cycle pulse on accepted press (and auto-repeats if enabled)
//  release_pulse  out  WIDTH  1-cycle pulse on accepted release
// BEHAVIOUR
//  - All channels identical and independent; bit i of every vector belongs to channel i.
//  - Sync: two flops per channel, reset to 1 (released). Synced sample s = ~sync2 (active-high).
//  - Per-channel FSM, states UP, WAIT_DN, DOWN, WAIT_UP; counter cnt of $clog2(DEBOUNCE_CYCLES+1) bits.
//    UP:      s==1 -> WAIT_DN, cnt<=1; else stay.
//    WAIT_DN: s==0 -> UP, cnt<=0 (bounce rejected); s==1 & cnt==DEBOUNCE_CYCLES-1 -> DOWN,
//             level_ah<=1, press_pulse<=1; else cnt<=cnt+1.
//    DOWN:    s==0 -> WAIT_UP, cnt<=1; else stay.
//    WAIT_UP: s==1 -> DOWN, cnt<=0; s==0 & cnt==DEBOUNCE_CYCLES-1 -> UP, level_ah<=0,
//             release_pulse<=1; else cnt<=cnt+1.
//  - DEBOUNCE_CYCLES==1: WAIT_* accepts on its first cycle (UP->WAIT_DN->DOWN, no counting).
//  - Latency: btn_n falling edge (clean) -> level_ah/press_pulse high after 2 (sync) + DEBOUNCE_CYCLES
//    clocks, +/-1 for async sampling. press_pulse and level_ah rise in the same cycle.
//  - Pulses are registered, exactly 1 cycle wide, never both high on one channel in one cycle.
//  - Counter saturates at its compare value; never wraps.
//  - Reset (any state, mid-count, held button): sync flops<=1, state<=UP, cnt<=0, level_ah<=0,
//    press_pulse<=0, release_pulse<=0. A button held through reset deassertion is re-debounced
//    from UP and yields one press_pulse after 2+DEBOUNCE_CYCLES cycles.
//  - Top level derives its core reset from level_ah (e.g. both buttons held); this block itself
//    is reset only by Reset.
// CONFIGURATION
//  AUTO_REPEAT_EN defined: in DOWN, a hold counter runs from accept; first extra press_pulse at
//    REPEAT_DELAY cycles after the accepting press, then every REPEAT_PERIOD cycles while DOWN.
//    Leaving DOWN (to WAIT_UP) clears the hold counter; returning WAIT_UP->DOWN restarts it from 0.
//    Hold counter cleared by Reset.
//  AUTO_REPEAT_EN undefined: exactly one press_pulse per accepted press; no hold counter logic,
//    REPEAT_* parameters ignored.
// TESTING  (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, WIDTH=2)
//  1 Reset 3 cycles with btn_n=2'b00 -> level_ah=0, pulses=0 during reset; press_pulse[1:0]=2'b11
//    exactly once, 6 cycles after Reset deasserts (+/-1).
//  2 btn_n[0] 1->0 held -> press_pulse[0] one cycle, level_ah[0]=1 at 2+4 cycles; ch1 untouched.
//  3 Bounce: btn_n[0] low 3 cycles, high 1, low held -> no pulse until 4 stable low cycles
//    after the last bounce; then a single press_pulse[0].
//  4 Release: from DOWN set btn_n[0]=1 -> release_pulse[0] one cycle, level_ah[0]=0 after 2+4;
//    a 2-cycle high glitch while DOWN -> no release_pulse, level_ah stays 1.
//  5 Reset asserted while ch0 in WAIT_DN with cnt=2 -> all outputs 0 next edge; after release
//    with btn_n[0]=1, no press_pulse ever.
//  6 AUTO_REPEAT_EN: hold btn_n[0]=0 60 cycles past accept -> press_pulse[0] at accept, +20,
//    +28, +36, +44, +52; without macro only at accept.

Source files
------------

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Cleans up raw active-low push buttons for the SLC-3 board top. Every
// channel is independent and identical:
//   1. two-flop synchronizer (resets to "released")
//   2. debounce FSM: a new level is accepted only after DEBOUNCE_CYCLES
//      consecutive synchronized samples at that level
//   3. registered one-cycle press / release pulses, issued in the same
//      cycle that the debounced level changes
//
// Optional feature, compile-time macro AUTO_REPEAT_EN:
//   While a button stays accepted-down, extra press pulses are produced
//   REPEAT_DELAY cycles after the accepting press and then every
//   REPEAT_PERIOD cycles. Without the macro there is exactly one press
//   pulse per accepted press and the REPEAT_* parameters are ignored.
//
// Parameters
//   WIDTH           number of button channels
//   DEBOUNCE_CYCLES stable synced samples needed to accept a level (>= 1)
//   REPEAT_DELAY    hold cycles before the first auto-repeat pulse
//   REPEAT_PERIOD   cycles between later auto-repeat pulses (>= 1)
//
// Ports
//   Clk           in   1      system clock, rising edge
//   Reset         in   1      synchronous, active-high
//   btn_n         in   WIDTH  raw asynchronous buttons, 0 = pressed
//   level_ah      out  WIDTH  debounced level, 1 = pressed
//   press_pulse   out  WIDTH  one-cycle pulse on accepted press / repeat
//   release_pulse out  WIDTH  one-cycle pulse on accepted release
//
// Handshake: none. Outputs are plain registered levels/pulses; consumers
// sample them on the same Clk and must not assume any backpressure.
// -----------------------------------------------------------------------------
module button_conditioner #(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] btn_n,
   output logic [WIDTH-1:0] level_ah,
   output logic [WIDTH-1:0] press_pulse,
   output logic [WIDTH-1:0] release_pulse
);

   // ---------------------------------------------------------------------------
   // Types and constants
   // ---------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_UP      = 2'd0,
      ST_WAIT_DN = 2'd1,
      ST_DOWN    = 2'd2,
      ST_WAIT_UP = 2'd3
   } state_e;

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   // Accept threshold. Using >= instead of == lets DEBOUNCE_CYCLES==1 accept
   // on the first WAIT_* cycle even though that state is entered with cnt=1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // ---------------------------------------------------------------------------
   // Synchronizer
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] sync2_q, sync2_d;
   logic [WIDTH-1:0] samp;               // synchronized, active-high

   assign sync1_d = btn_n;
   assign sync2_d = sync1_q;
   assign samp    = ~sync2_q;

   // ---------------------------------------------------------------------------
   // Per-channel debounce state
   // ---------------------------------------------------------------------------
   state_e           state_q [WIDTH];
   state_e           state_d [WIDTH];
   logic [CNT_W-1:0] cnt_q   [WIDTH];
   logic [CNT_W-1:0] cnt_d   [WIDTH];
   logic [WIDTH-1:0] level_q, level_d;
   logic [WIDTH-1:0] press_q, press_d;
   logic [WIDTH-1:0] release_q, release_d;

`ifdef AUTO_REPEAT_EN
   // Hold counter runs only in DOWN. It climbs to REPEAT_DELAY (first
   // repeat) and then cycles between REPEAT_DELAY and
   // REPEAT_DELAY+REPEAT_PERIOD, so it never needs more than HOLD_W bits.
   localparam int HOLD_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
   localparam logic [HOLD_W-1:0] HOLD_FIRST = HOLD_W'(REPEAT_DELAY);
   localparam logic [HOLD_W-1:0] HOLD_WRAP  = HOLD_W'(REPEAT_DELAY + REPEAT_PERIOD);
   localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

   logic [HOLD_W-1:0] hold_q [WIDTH];
   logic [HOLD_W-1:0] hold_d [WIDTH];
`else
   // REPEAT_* are intentionally unused in this build.
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

   // ---------------------------------------------------------------------------
   // Next-state / output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
`ifdef AUTO_REPEAT_EN
         hold_d[i]  = '0;           // cleared everywhere except while held DOWN
`endif
         case (state_q[i])
            ST_UP: begin
               if (samp[i]) begin
                  state_d[i] = ST_WAIT_DN;
                  cnt_d[i]   = CNT_ONE;
               end
            end

            ST_WAIT_DN: begin
               if (!samp[i]) begin
                  // bounce: abandon the candidate press
                  state_d[i] = ST_UP;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] >= CNT_LAST) begin
                  state_d[i]  = ST_DOWN;
                  cnt_d[i]    = '0;
                  level_d[i]  = 1'b1;
                  press_d[i]  = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end
            end

            ST_DOWN: begin
               if (!samp[i]) begin
                  state_d[i] = ST_WAIT_UP;
                  cnt_d[i]   = CNT_ONE;
               end else begin
`ifdef AUTO_REPEAT_EN
                  if (hold_q[i] + HOLD_ONE == HOLD_WRAP) begin
                     hold_d[i]  = HOLD_FIRST;
                     press_d[i] = 1'b1;
                  end else if (hold_q[i] + HOLD_ONE == HOLD_FIRST) begin
                     hold_d[i]  = HOLD_FIRST;
                     press_d[i] = 1'b1;
                  end else begin
                     hold_d[i] = hold_q[i] + HOLD_ONE;
                  end
`endif
               end
            end

            ST_WAIT_UP: begin
               if (samp[i]) begin
                  // glitch while held: stay pressed, no release
                  state_d[i] = ST_DOWN;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] >= CNT_LAST) begin
                  state_d[i]   = ST_UP;
                  cnt_d[i]     = '0;
                  level_d[i]   = 1'b0;
                  release_d[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end
            end

            default: begin
               state_d[i] = ST_UP;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            state_q[i] <= ST_UP;
            cnt_q[i]   <= '0;
`ifdef AUTO_REPEAT_EN
            hold_q[i]  <= '0;
`endif
         end
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         for (int i = 0; i < WIDTH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
`ifdef AUTO_REPEAT_EN
            hold_q[i]  <= hold_d[i];
`endif
         end
      end
   end

   assign level_ah      = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8, WIDTH=2. Inputs change on the falling clock edge, so a
// btn_n change made after cycle c is first accepted in cycle c+2+4.
// Expected pulse events {cycle, press[1:0], release[1:0]} go into exp_q
// when stimulus is driven; step() pops and compares them as cycles elapse
// and flags any pulse that was not expected.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

   localparam int WIDTH = 2;
   localparam int DEB   = 4;
   localparam int LAT   = 2 + DEB;
   localparam int W     = 28;          // {cycle[23:0], press[1:0], release[1:0]}

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic             clk   = 1'b0;
   logic             reset = 1'b1;
   logic [WIDTH-1:0] btn_n = '1;
   logic [WIDTH-1:0] level_ah;
   logic [WIDTH-1:0] press_pulse;
   logic [WIDTH-1:0] release_pulse;

   always #5 clk = ~clk;

   button_conditioner #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (8)
   ) dut (
      .Clk           (clk),
      .Reset         (reset),
      .btn_n         (btn_n),
      .level_ah      (level_ah),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic [W-1:0] exp_q[$];

   task automatic push_exp(input int at, input logic [1:0] pr, input logic [1:0] rl);
      logic [23:0] at24;
      at24 = at[23:0];
      exp_q.push_back({at24, pr, rl});
   endtask

   // One clock cycle; compare pulses at the falling edge.
   task automatic step();
      logic [W-1:0] e;
      logic [3:0]   obs;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      obs = {press_pulse, release_pulse};
      while (exp_q.size() > 0 && int'(exp_q[0][W-1:4]) < cyc) begin
         e = exp_q.pop_front();
         checks++;
         failures++;
         $display("FAIL missed_pulse: cycle %0d expected press=%b release=%b, pulse missing",
                  e[W-1:4], e[3:2], e[1:0]);
      end
      if (exp_q.size() > 0 && int'(exp_q[0][W-1:4]) == cyc) begin
         e = exp_q.pop_front();
         checks++;
         if (obs !== e[3:0]) begin
            failures++;
            $display("FAIL pulse_value: cycle %0d got press=%b release=%b, expected press=%b release=%b",
                     cyc, obs[3:2], obs[1:0], e[3:2], e[1:0]);
         end
      end else if (obs !== 4'b0000) begin
         checks++;
         failures++;
         $display("FAIL unexpected_pulse: cycle %0d got press=%b release=%b, expected none",
                  cyc, obs[3:2], obs[1:0]);
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic drain(input string name);
      run(LAT + 2);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain: %0d expected events left, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // ---------------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b1;
      btn_n = 2'b00;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (level_ah !== 2'b00 || press_pulse !== 2'b00 || release_pulse !== 2'b00) begin
            failures++;
            $display("FAIL reset_outputs: level=%b press=%b release=%b, expected all 0",
                     level_ah, press_pulse, release_pulse);
         end
      end
      reset = 1'b0;                      // buttons held through deassertion
      push_exp(cyc + LAT, 2'b11, 2'b00);
      drain("reset_held");
      checks++;
      if (level_ah !== 2'b11) begin
         failures++;
         $display("FAIL reset_held_level: level=%b, expected 11", level_ah);
      end
      btn_n = 2'b11;
      push_exp(cyc + LAT, 2'b00, 2'b11);
      drain("reset_release");
      checks++;
      if (level_ah !== 2'b00) begin
         failures++;
         $display("FAIL reset_release_level: level=%b, expected 00", level_ah);
      end
   endtask

   task automatic test_press();
      btn_n = 2'b10;
      push_exp(cyc + LAT, 2'b01, 2'b00);
      run(LAT - 1);
      checks++;
      if (level_ah !== 2'b00) begin
         failures++;
         $display("FAIL press_early_level: level=%b, expected 00", level_ah);
      end
      step();
      checks++;
      if (level_ah !== 2'b01) begin
         failures++;
         $display("FAIL press_level: level=%b, expected 01", level_ah);
      end
      drain("press");
   endtask

   task automatic test_release();
      btn_n = 2'b11;
      push_exp(cyc + LAT, 2'b00, 2'b01);
      drain("release");
      checks++;
      if (level_ah !== 2'b00) begin
         failures++;
         $display("FAIL release_level: level=%b, expected 00", level_ah);
      end
      // re-press, then a 2-cycle high glitch must be swallowed
      btn_n = 2'b10;
      push_exp(cyc + LAT, 2'b01, 2'b00);
      drain("repress");
      btn_n = 2'b11;
      run(2);
      btn_n = 2'b10;
      run(LAT + 4);
      checks++;
      if (level_ah !== 2'b01) begin
         failures++;
         $display("FAIL glitch_level: level=%b, expected 01", level_ah);
      end
      btn_n = 2'b11;
      push_exp(cyc + LAT, 2'b00, 2'b01);
      drain("glitch_release");
   endtask

   task automatic test_bounce();
      btn_n = 2'b10;
      run(3);
      btn_n = 2'b11;
      run(1);
      btn_n = 2'b10;
      push_exp(cyc + LAT, 2'b01, 2'b00);
      drain("bounce");
      checks++;
      if (level_ah !== 2'b01) begin
         failures++;
         $display("FAIL bounce_level: level=%b, expected 01", level_ah);
      end
      btn_n = 2'b11;
      push_exp(cyc + LAT, 2'b00, 2'b01);
      drain("bounce_release");
   endtask

   task automatic test_reset_mid();
      btn_n = 2'b01;                     // ch1 down first so reset has a level to clear
      push_exp(cyc + LAT, 2'b10, 2'b00);
      drain("mid_ch1");
      btn_n = 2'b00;                     // ch0 starts counting
      run(4);                            // ch0 now WAIT_DN with cnt=2
      reset = 1'b1;
      btn_n = 2'b11;
      step();
      checks++;
      if (level_ah !== 2'b00 || press_pulse !== 2'b00 || release_pulse !== 2'b00) begin
         failures++;
         $display("FAIL mid_reset_outputs: level=%b press=%b release=%b, expected all 0",
                  level_ah, press_pulse, release_pulse);
      end
      run(2);
      reset = 1'b0;
      drain("mid_after");
      checks++;
      if (level_ah !== 2'b00) begin
         failures++;
         $display("FAIL mid_after_level: level=%b, expected 00", level_ah);
      end
   endtask

   task automatic test_repeat();
      int acc;
      btn_n = 2'b10;
      acc = cyc + LAT;
      push_exp(acc, 2'b01, 2'b00);
`ifdef AUTO_REPEAT_EN
      for (int k = 0; k < 5; k++) push_exp(acc + 20 + 8 * k, 2'b01, 2'b00);
`endif
      run(LAT + 56);
      checks++;
      if (level_ah !== 2'b01) begin
         failures++;
         $display("FAIL repeat_level: level=%b, expected 01", level_ah);
      end
      btn_n = 2'b11;
      push_exp(cyc + LAT, 2'b00, 2'b01);
      drain("repeat");
   endtask

   task automatic test_back_to_back();
      btn_n = 2'b10;
      push_exp(cyc + LAT, 2'b01, 2'b00);
      run(2);
      btn_n = 2'b00;
      push_exp(cyc + LAT, 2'b10, 2'b00);
      drain("b2b_press");
      checks++;
      if (level_ah !== 2'b11) begin
         failures++;
         $display("FAIL b2b_level: level=%b, expected 11", level_ah);
      end
      btn_n = 2'b11;
      push_exp(cyc + LAT, 2'b00, 2'b11);
      drain("b2b_release");
      checks++;
      if (level_ah !== 2'b00) begin
         failures++;
         $display("FAIL b2b_release_level: level=%b, expected 00", level_ah);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------------
   initial begin
      test_reset();
      test_press();
      test_release();
      test_bounce();
      test_reset_mid();
      test_repeat();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
